// File: rtl/snake_food_pkg.sv
// snake_food_pkg: grid limits, main-FSM codes and food-FSM states for snake_food
package snake_food_pkg;
  localparam int GRID_W = 32;
  localparam int GRID_H = 24;
  localparam int MAX_LEN = 20;
  localparam int COORD_W = $clog2(GRID_W);
  localparam int BODY_W = MAX_LEN * COORD_W;
  typedef logic [COORD_W-1:0] coord_t;
  localparam coord_t MAX_Y = coord_t'(GRID_H - 1);
  localparam coord_t INITIAL_FOOD_X = 5'd20;
  localparam coord_t INITIAL_FOOD_Y = 5'd12;
  localparam logic [2:0] MAIN_START = 3'd0;
  localparam logic [2:0] MAIN_GAME1 = 3'd1;
  localparam logic [2:0] MAIN_GAME2 = 3'd2;
  localparam logic [2:0] MAIN_GAME3 = 3'd3;
  localparam logic [2:0] MAIN_WIN = 3'd4;
  localparam logic [2:0] MAIN_LOSE = 3'd5;
  typedef enum logic [1:0] {IDLE, SCAN, GEN, CHECK} food_st_t;
  function automatic coord_t seg_at(input logic [BODY_W-1:0] v, input logic [4:0] i);
    return v[int'(i)*COORD_W +: COORD_W];
  endfunction
endpackage

// File: rtl/snake_lfsr10.sv
// snake_lfsr10: free-running 10-bit maximal-length LFSR, polynomial x^10+x^7+1
module snake_lfsr10 (
  input  logic       clk,
  input  logic       rst_global_n,
  output logic [9:0] q
);
  always_ff @(posedge clk or negedge rst_global_n)
    if (!rst_global_n) q <= 10'h001;
    else q <= {q[8:0], q[9] ^ q[6]};
endmodule

// File: rtl/snake_food.sv
// snake_food: eat/self-hit detection and food placement, one segment compare per cycle
module snake_food
  import snake_food_pkg::*;
(
  input  logic              clk,
  input  logic              rst_global_n,
  input  logic [2:0]        state,
  input  logic              move,
  input  logic [4:0]        snake_len,
  input  logic [BODY_W-1:0] snake_x,
  input  logic [BODY_W-1:0] snake_y,
  output coord_t            food_x,
  output coord_t            food_y,
  output logic              ate,
  output logic              self_hit,
  output logic              busy
);
  food_st_t r_st, w_st_nx;
  logic [4:0] r_idx, w_idx_nx, r_len, w_len_nx;
  coord_t r_head_x, r_head_y, r_cand_x, r_cand_y, r_food_x, r_food_y;
  coord_t w_head_x_nx, w_head_y_nx, w_cand_x_nx, w_cand_y_nx, w_food_x_nx, w_food_y_nx;
  logic r_ate, r_hit, w_ate_nx, w_hit_nx;
  logic [9:0] w_lfsr;
  coord_t w_seg_x, w_seg_y, w_ref_x, w_ref_y, w_h0_x, w_h0_y;
  logic w_run, w_match, w_last;

  snake_lfsr10 u_lfsr (.clk(clk), .rst_global_n(rst_global_n), .q(w_lfsr));

  assign w_run = state inside {MAIN_GAME1, MAIN_GAME2, MAIN_GAME3};
  assign w_h0_x = snake_x[COORD_W-1:0];
  assign w_h0_y = snake_y[COORD_W-1:0];
  assign w_seg_x = seg_at(snake_x, r_idx);
  assign w_seg_y = seg_at(snake_y, r_idx);
  // SCAN and CHECK share the single segment comparator
  assign w_ref_x = (r_st == SCAN) ? r_head_x : r_cand_x;
  assign w_ref_y = (r_st == SCAN) ? r_head_y : r_cand_y;
  assign w_match = (w_seg_x == w_ref_x) && (w_seg_y == w_ref_y);
  assign w_last = r_idx == r_len - 5'd1;

  always_comb begin
    w_st_nx = r_st;
    w_idx_nx = r_idx;
    w_len_nx = r_len;
    w_head_x_nx = r_head_x;
    w_head_y_nx = r_head_y;
    w_cand_x_nx = r_cand_x;
    w_cand_y_nx = r_cand_y;
    w_food_x_nx = r_food_x;
    w_food_y_nx = r_food_y;
    w_ate_nx = r_ate;
    w_hit_nx = r_hit;
    if (state == MAIN_START) begin
      w_st_nx = IDLE;
      w_idx_nx = '0;
      w_ate_nx = 1'b0;
      w_hit_nx = 1'b0;
      w_food_x_nx = INITIAL_FOOD_X;
      w_food_y_nx = INITIAL_FOOD_Y;
    end else if (w_run) begin
      case (r_st)
        IDLE: if (move) begin
          w_head_x_nx = w_h0_x;
          w_head_y_nx = w_h0_y;
          w_len_nx = snake_len;
          w_idx_nx = 5'd1;
          w_ate_nx = (w_h0_x == r_food_x) && (w_h0_y == r_food_y);
          w_st_nx = SCAN;
        end
        SCAN: begin
          w_hit_nx = r_hit | w_match;
          w_idx_nx = r_idx + 5'd1;
          w_st_nx = w_last ? (r_ate ? GEN : IDLE) : SCAN;
        end
        GEN: if (w_lfsr[4:0] <= MAX_Y) begin
          w_cand_x_nx = w_lfsr[9:5];
          w_cand_y_nx = w_lfsr[4:0];
          w_idx_nx = '0;
          w_st_nx = CHECK;
        end
        CHECK: if (w_match) w_st_nx = GEN;
        else if (w_last) begin
          w_food_x_nx = r_cand_x;
          w_food_y_nx = r_cand_y;
          w_st_nx = IDLE;
        end else w_idx_nx = r_idx + 5'd1;
        default: w_st_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_global_n)
    if (!rst_global_n) begin
      r_st <= IDLE;
      r_idx <= '0;
      r_len <= 5'd5;
      r_head_x <= '0;
      r_head_y <= '0;
      r_cand_x <= '0;
      r_cand_y <= '0;
      r_food_x <= INITIAL_FOOD_X;
      r_food_y <= INITIAL_FOOD_Y;
      r_ate <= 1'b0;
      r_hit <= 1'b0;
    end else begin
      r_st <= w_st_nx;
      r_idx <= w_idx_nx;
      r_len <= w_len_nx;
      r_head_x <= w_head_x_nx;
      r_head_y <= w_head_y_nx;
      r_cand_x <= w_cand_x_nx;
      r_cand_y <= w_cand_y_nx;
      r_food_x <= w_food_x_nx;
      r_food_y <= w_food_y_nx;
      r_ate <= w_ate_nx;
      r_hit <= w_hit_nx;
    end

  assign food_x = r_food_x;
  assign food_y = r_food_y;
  assign ate = r_ate;
  assign self_hit = r_hit;
  assign busy = r_st != IDLE;
endmodule

// File: tb/tb_snake_food.sv
// tb_snake_food: random and directed moves checked against a pass-level food/collision model
module tb_snake_food;
  import snake_food_pkg::*;
  logic clk = 1'b0, rst_global_n = 1'b1, move = 1'b0;
  logic [2:0] state = MAIN_START;
  logic [4:0] snake_len = 5'd5;
  logic [BODY_W-1:0] snake_x = '0, snake_y = '0;
  coord_t food_x, food_y;
  logic ate, self_hit, busy;
  int n, vecs, errs;
  logic [4:0] bx[20], by[20];
  logic [4:0] fx = 5'd20, fy = 5'd12;
  bit m_ate, m_hit;

  snake_food dut (.clk(clk), .rst_global_n(rst_global_n), .state(state), .move(move),
    .snake_len(snake_len), .snake_x(snake_x), .snake_y(snake_y), .food_x(food_x),
    .food_y(food_y), .ate(ate), .self_hit(self_hit), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_global_n)
    if (!rst_global_n) n <= 0;
    else n <= n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] lfsr_at(input int k);
    logic [9:0] v = 10'h001;
    for (int s = 0; s < k % 1023; s++) v = {v[8:0], v[9] ^ v[6]};
    return v;
  endfunction

  task automatic pack_body();
    for (int k = 0; k < 20; k++) begin
      snake_x[k*5 +: 5] = bx[k];
      snake_y[k*5 +: 5] = by[k];
    end
  endtask

  task automatic plain_body(input logic [4:0] hx, input logic [4:0] hy);
    for (int k = 0; k < 20; k++) begin
      bx[k] = 5'(k);
      by[k] = 5'((k + 1) % 24);
    end
    bx[0] = hx;
    by[0] = hy;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ate"}, ate, m_ate);
    chk({tag, "_hit"}, self_hit, m_hit);
    chk({tag, "_fx"}, food_x, fx);
    chk({tag, "_fy"}, food_y, fy);
  endtask

  task automatic go_start();
    state = MAIN_START;
    @(negedge clk);
    state = 3'($urandom_range(1, 3));
    fx = 5'd20; fy = 5'd12; m_ate = 0; m_hit = 0;
    check_idle("start");
  endtask

  // predicts the edge on which the pass finishes and the committed food
  task automatic apply_move(input int len, input bit extra);
    int n0, t, done, hit_j, guard;
    logic [9:0] v;
    pack_body();
    snake_len = 5'(len);
    move = 1'b1;
    n0 = n;
    m_ate = (bx[0] == fx) && (by[0] == fy);
    for (int k = 1; k < len; k++) if (bx[k] == bx[0] && by[k] == by[0]) m_hit = 1;
    done = n0 + len - 1;
    if (m_ate) begin
      t = n0 + len;
      guard = 0;
      while (guard < 5000) begin
        guard++;
        v = lfsr_at(t);
        if (v[4:0] > 5'd23) t++;
        else begin
          hit_j = -1;
          for (int k = 0; k < len; k++)
            if (hit_j < 0 && bx[k] == v[9:5] && by[k] == v[4:0]) hit_j = k;
          if (hit_j < 0) begin
            done = t + len;
            fx = v[9:5];
            fy = v[4:0];
            break;
          end
          t = t + 2 + hit_j;
        end
      end
    end
    @(negedge clk);
    move = 1'b0;
    snake_len = 5'($urandom_range(5, 20));
    chk("ate_on_move", ate, m_ate);
    chk("busy_on_move", busy, 1);
    guard = 0;
    while (busy === 1'b1 && guard < 3000) begin
      guard++;
      if (extra && n == done) move = 1'b1;
      @(negedge clk);
      move = 1'b0;
    end
    chk("pass_timeout", guard < 3000, 1);
    chk("pass_end_cycle", n, done + 1);
    check_idle("after_pass");
  endtask

  initial begin
    #1 rst_global_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_global_n = 1'b1;
    go_start();
    plain_body(5'd20, 5'd12);
    apply_move(5, 0);
    plain_body(5'd10, 5'd10);
    bx[3] = 5'd10; by[3] = 5'd10;
    apply_move(5, 0);
    go_start();
    plain_body(5'd10, 5'd10);
    bx[7] = 5'd10; by[7] = 5'd10;
    apply_move(5, 0);
    plain_body(fx, fy);
    apply_move(8, 1);
    state = MAIN_WIN;
    plain_body(fx, fy);
    pack_body();
    move = 1'b1;
    @(negedge clk);
    move = 1'b0;
    @(negedge clk);
    check_idle("win_hold");
    state = MAIN_GAME2;
    for (int it = 0; it < 40; it++) begin
      if (it % 6 == 5) go_start();
      state = 3'($urandom_range(1, 3));
      for (int k = 0; k < 20; k++) begin
        bx[k] = 5'($urandom_range(0, 31));
        by[k] = 5'($urandom_range(0, 23));
      end
      if ($urandom_range(0, 1) == 1) begin bx[0] = fx; by[0] = fy; end
      if ($urandom_range(0, 3) == 0) begin
        int j = $urandom_range(1, 19);
        bx[j] = bx[0]; by[j] = by[0];
      end
      apply_move($urandom_range(5, 20), $urandom_range(0, 1) == 1);
    end
    plain_body(fx, fy);
    pack_body();
    snake_len = 5'd6;
    move = 1'b1;
    @(negedge clk);
    move = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_global_n = 1'b0;
    #1;
    fx = 5'd20; fy = 5'd12; m_ate = 0; m_hit = 0;
    check_idle("reset_mid_pass");
    @(negedge clk);
    rst_global_n = 1'b1;
    state = MAIN_GAME1;
    plain_body(5'd20, 5'd12);
    apply_move(6, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
